ssi_read_scheduler: RTL and testbench

//  Sequences and shares a single SSI encoder reader between NREQ client requesters and an internal periodic sampler.

---
 rtl/ssi_read_scheduler.sv | 172 +++++++++++++++++
 tb/tb_ssi_read_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssi_read_scheduler.sv
// Shares one SSI encoder reader between NREQ clients and a periodic sampler:
// round-robin pick, one key pulse, wait for done/timeout, then enforce the recovery gap.
module ssi_read_scheduler #(
  parameter int NREQ    = 4,
  parameter int PERIOD  = 20000,
  parameter int TIMEOUT = 6000,
  parameter int GAP     = 5600
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            auto_en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [31:0]     data_o,
  output logic            err_o,
  output logic            auto_valid,
  output logic            busy,
  output logic [7:0]      overrun_cnt,
  output logic            ssi_key,
  input  logic            ssi_done,
  input  logic [31:0]     ssi_data
);
  localparam int NS = NREQ + 1;
  localparam int SW = $clog2(NS);
  localparam int PW = (PERIOD > 0) ? $clog2(PERIOD + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'((PERIOD > 0) ? PERIOD - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [SW-1:0] AUTO_SLOT = SW'(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_KEY, S_WAIT, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   cur_q, cur_d, rr_q, rr_d;
  logic [PW-1:0]   tmr_q, tmr_d;
  logic            pend_q, pend_d;
  logic [7:0]      ovr_q, ovr_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            av_q, av_d, err_q, err_d, key_q, key_d;
  logic [31:0]     data_q, data_d;

  logic [NS-1:0]   slots;
  logic [SW:0]     idx;
  logic [SW-1:0]   pick;
  logic            pick_ok, tick, auto_clr;

  // Round-robin search starting at rr_q, which holds the slot after the last winner.
  always_comb begin
    slots   = {pend_q, req};
    pick_ok = 1'b0;
    pick    = rr_q;
    idx     = '0;
    for (int k = 0; k < NS; k++) begin
      idx = {1'b0, rr_q} + (SW+1)'(k);
      if (idx >= (SW+1)'(NS)) idx = idx - (SW+1)'(NS);
      if (!pick_ok && slots[idx[SW-1:0]]) begin
        pick_ok = 1'b1;
        pick    = idx[SW-1:0];
      end
    end
  end

  // A tick coinciding with the KEY-cycle clear re-arms pend rather than counting an overrun.
  always_comb begin
    tick     = auto_en && (PERIOD > 0) && (tmr_q == PER_LAST);
    auto_clr = (state_q == S_KEY) && (cur_q == AUTO_SLOT);
    tmr_d    = (!auto_en || tick) ? '0 : tmr_q + PW'(1);
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    if (!auto_en) begin
      pend_d = 1'b0;
    end else if (tick) begin
      if (pend_q && !auto_clr) begin
        if (ovr_q != 8'hff) ovr_d = ovr_q + 8'd1;
      end else begin
        pend_d = 1'b1;
      end
    end else if (auto_clr) begin
      pend_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rr_d    = rr_q;
    tmo_d   = tmo_q;
    gcnt_d  = gcnt_q;
    ack_d   = '0;
    av_d    = 1'b0;
    key_d   = 1'b0;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: if (pick_ok) begin
        cur_d   = pick;
        rr_d    = (pick == SW'(NS - 1)) ? '0 : pick + SW'(1);
        state_d = S_KEY;
      end
      S_KEY: begin
        key_d   = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ssi_done || tmo_q == TMO_LAST) begin
          if (ssi_done) begin
            data_d = ssi_data;
            err_d  = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
          if (cur_q == AUTO_SLOT) av_d = 1'b1;
          else                    ack_d = NREQ'(1) << cur_q;
          gcnt_d  = '0;
          state_d = S_GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GAP: begin
        if (gcnt_q == GAP_LAST) state_d = S_IDLE;
        else                    gcnt_d  = gcnt_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      rr_q    <= '0;
      tmr_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= '0;
      tmo_q   <= '0;
      gcnt_q  <= '0;
      ack_q   <= '0;
      av_q    <= 1'b0;
      err_q   <= 1'b0;
      key_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rr_q    <= rr_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
      gcnt_q  <= gcnt_d;
      ack_q   <= ack_d;
      av_q    <= av_d;
      err_q   <= err_d;
      key_q   <= key_d;
      data_q  <= data_d;
    end
  end

  assign ack         = ack_q;
  assign auto_valid  = av_q;
  assign err_o       = err_q;
  assign data_o      = data_q;
  assign ssi_key     = key_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun_cnt = ovr_q;
endmodule

// File: tb/tb_ssi_read_scheduler.sv
// Bench for ssi_read_scheduler with scaled timing: reader model, scoreboard of expected
// completions, a vector table for single reads and hand-written multi-read sequences.
module tb_ssi_read_scheduler;
  localparam int NREQ = 4, PERIOD = 50, TIMEOUT = 30, GAP = 20;

  logic            clk = 1'b0, rst_n = 1'b0, auto_en = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] ack;
  logic [31:0]     data_o;
  logic            err_o, auto_valid, busy, ssi_key;
  logic [7:0]      overrun_cnt;
  logic            ssi_done = 1'b0;
  logic [31:0]     ssi_data = '0;

  ssi_read_scheduler #(.NREQ(NREQ), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .auto_en(auto_en), .req(req), .ack(ack), .data_o(data_o),
    .err_o(err_o), .auto_valid(auto_valid), .busy(busy), .overrun_cnt(overrun_cnt),
    .ssi_key(ssi_key), .ssi_done(ssi_done), .ssi_data(ssi_data));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic            av;
    logic            err;
    logic [31:0]     data;
  } exp_t;

  exp_t exp_q[$];
  int   key_cyc[$];
  int   av_cyc[$];
  int   cyc = 0, errors = 0, checks = 0;
  int   nack = 0, nav = 0, last_done = -100, ack_cyc = 0;
  int   rd_delay = 10, nkey = 0;
  bit   sb_on = 1'b1;

  function automatic logic [31:0] wfn(input int k);
    return {9'd0, 23'(k * 32'h1357 + 32'h0abc)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int t = 0;
    while (busy && t < lim) begin step(1); t++; end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_done(input int n, input int lim);
    int t = 0;
    while ((nack + nav) < n && t < lim) begin step(1); t++; end
    if ((nack + nav) < n) chk("done_timeout", nack + nav, n);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reader model: answers rd_delay cycles after a key; rd_delay <= 0 means never.
  initial begin
    int  k;
    bit  abort;
    forever begin
      @(negedge clk);
      if (rst_n && ssi_key) begin
        k = nkey;
        nkey++;
        if (rd_delay > 0) begin
          abort = 1'b0;
          for (int i = 0; i < rd_delay; i++) begin
            @(posedge clk);
            if (!rst_n) abort = 1'b1;
          end
          if (!abort) begin
            #1 ssi_done = 1'b1;
            ssi_data = wfn(k);
            @(posedge clk);
            #1 ssi_done = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: compares each completion against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ssi_done) last_done = cyc;
        if (ssi_key) key_cyc.push_back(cyc);
        if (ack != '0 || auto_valid) begin
          ack_cyc = cyc;
          if (auto_valid) begin nav++; av_cyc.push_back(cyc); end
          else nack++;
          if (sb_on) begin
            if (exp_q.size() == 0) chk("unexpected_done", {ack, auto_valid}, 0);
            else begin
              e = exp_q.pop_front();
              chk("sb_ack", ack, e.ack);
              chk("sb_auto", auto_valid, e.av);
              chk("sb_err", err_o, e.err);
              chk("sb_data", data_o, e.data);
              if (!err_o) chk("ack_after_done", cyc, last_done + 1);
            end
          end
        end
      end
    end
  end

  typedef struct {
    logic [NREQ-1:0] req;
    int              dly;
    logic            err;
    int              lat;
  } vec_t;

  initial begin
    vec_t        vt[5];
    logic [31:0] last_word;
    int          c0, base, prev_ack, t;
    exp_t        e;

    // req, reader delay, expected err, expected key-to-ack cycles
    vt[0] = '{4'b0001, 10, 1'b0, 11};
    vt[1] = '{4'b0100, -1, 1'b1, TIMEOUT};
    vt[2] = '{4'b1000, TIMEOUT - 1, 1'b0, TIMEOUT};
    vt[3] = '{4'b0010, TIMEOUT, 1'b1, TIMEOUT};
    vt[4] = '{4'b0001, 1, 1'b0, 2};

    rst_n = 1'b0;
    step(3);
    chk("rst_ack", ack, 0);
    chk("rst_auto_valid", auto_valid, 0);
    chk("rst_err", err_o, 0);
    chk("rst_key", ssi_key, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_o, 0);
    chk("rst_overrun", overrun_cnt, 0);
    rst_n = 1'b1;
    step(2);
    last_word = '0;
    prev_ack  = -1000;

    for (int i = 0; i < 5; i++) begin
      wait_idle(200);
      rd_delay = vt[i].dly;
      key_cyc.delete();
      base = nack + nav;
      e.ack = vt[i].req; e.av = 1'b0; e.err = vt[i].err;
      e.data = vt[i].err ? last_word : wfn(nkey);
      if (!vt[i].err) last_word = e.data;
      exp_q.push_back(e);
      req = vt[i].req;
      c0  = cyc;
      wait_done(base + 1, 200);
      req = '0;
      chk("nkeys", key_cyc.size(), 1);
      if (key_cyc.size() > 0) begin
        chk("key_lat", key_cyc[0] - c0, 2);
        chk("ack_lat", ack_cyc - key_cyc[0], vt[i].lat);
        chk("gap_respected", (key_cyc[0] - prev_ack) >= GAP + 1, 1);
      end
      prev_ack = ack_cyc;
    end
    wait_idle(200);

    // All clients at once after reset: round-robin from slot 0.
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    rd_delay = 10;
    key_cyc.delete();
    base = nack + nav;
    for (int j = 0; j < NREQ; j++) begin
      e.ack = NREQ'(1) << j; e.av = 1'b0; e.err = 1'b0; e.data = wfn(nkey + j);
      exp_q.push_back(e);
    end
    last_word = wfn(nkey + NREQ - 1);
    req = '1;
    for (int j = 0; j < NREQ; j++) begin
      wait_done(base + j + 1, 200);
      req[j] = 1'b0;
    end
    wait_idle(200);
    chk("rr_nkeys", key_cyc.size(), NREQ);
    for (int j = 1; j < NREQ && j < key_cyc.size(); j++)
      chk("key_spacing", key_cyc[j] - key_cyc[j-1], 10 + GAP + 3);

    // Periodic sampler alone.
    av_cyc.delete();
    base = nack + nav;
    for (int j = 0; j < 5; j++) begin
      e.ack = '0; e.av = 1'b1; e.err = 1'b0; e.data = wfn(nkey + j);
      exp_q.push_back(e);
    end
    auto_en = 1'b1;
    c0 = cyc;
    wait_done(base + 5, 400);
    auto_en = 1'b0;
    if (av_cyc.size() > 0) chk("auto_first_lat", av_cyc[0] - c0, PERIOD + 3 + 10);
    for (int j = 1; j < av_cyc.size(); j++) chk("auto_period", av_cyc[j] - av_cyc[j-1], PERIOD);
    chk("auto_overrun_zero", overrun_cnt, 0);
    wait_idle(200);

    // Saturating overrun: clients keep the reader busy so ticks pile up.
    sb_on = 1'b0;
    auto_en = 1'b1;
    req = '1;
    step(600);
    chk("overrun_started", overrun_cnt > 8'd0, 1);
    t = 0;
    while (overrun_cnt != 8'd255 && t < 40000) begin step(1); t++; end
    chk("overrun_reach_255", overrun_cnt, 255);
    step(400);
    chk("overrun_saturated", overrun_cnt, 255);
    req = '0;
    auto_en = 1'b0;
    wait_idle(300);
    step(2);
    sb_on = 1'b1;

    // Reset in WAIT after a slot-2 win: read aborted, RR pointer back at slot 0.
    rd_delay = 20;
    key_cyc.delete();
    req = 4'b0100;
    t = 0;
    while (key_cyc.size() == 0 && t < 20) begin step(1); t++; end
    chk("abort_keyed", key_cyc.size(), 1);
    step(5);
    rst_n = 1'b0;
    req = '0;
    step(1);
    chk("abort_ack", ack, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data", data_o, 0);
    chk("abort_err", err_o, 0);
    chk("abort_overrun", overrun_cnt, 0);
    step(2);
    rst_n = 1'b1;
    step(40);
    chk("abort_idle", busy, 0);
    chk("abort_no_rekey", key_cyc.size(), 1);
    rd_delay = 10;
    base = nack + nav;
    e.ack = 4'b0010; e.av = 1'b0; e.err = 1'b0; e.data = wfn(nkey);
    exp_q.push_back(e);
    e.ack = 4'b1000; e.data = wfn(nkey + 1);
    exp_q.push_back(e);
    req = 4'b1010;
    wait_done(base + 1, 200);
    req[1] = 1'b0;
    wait_done(base + 2, 200);
    req[3] = 1'b0;
    wait_idle(200);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
